// File: rtl/mode_counter_pkg.sv
// mode_counter_pkg
//   Shared definitions for mode_counter_n and its prescaler.
//   SEL_*      : encodings of the 2-bit select input (hold/down/up/load).
//   clamp_load : limits a load value to the highest legal count.
package mode_counter_pkg;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_DOWN = 2'b01;
    localparam logic [1:0] SEL_UP   = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    // Values above max would be unreachable counts, so they collapse to max.
    function automatic int unsigned clamp_load(input int unsigned value, input int unsigned max);
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/mode_counter_n_tick_prescaler.sv
// tick_prescaler
//   Counts enabled clock edges 0..PRESCALE-1 and flags the edge where the
//   phase wraps.
// Ports:
//   clock   in  rising-edge clock
//   Reset   in  asynchronous active-high reset
//   En      in  enable; 0 freezes the phase
//   clear   in  forces the phase back to 0 on an enabled edge
//   tick_en out combinational: this enabled edge completes a prescale period
//   tick    out registered copy of tick_en (one-cycle strobe)
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clock,
    input  logic Reset,
    input  logic En,
    input  logic clear,
    output logic tick_en,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] phase;

    assign tick_en = En && (phase == LAST);

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            phase <= '0;
            tick  <= 1'b0;
        end else begin
            // The strobe reflects the wrap even on a clearing edge, so
            // PRESCALE=1 always gives tick = En delayed by one cycle.
            tick <= tick_en;
            if (En) begin
                if (clear || tick_en)
                    phase <= '0;
                else
                    phase <= phase + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mode_counter_n.sv
// mode_counter_n
//   Modulo (MAX_COUNT+1) counter with hold/down/up/load modes, enable and
//   prescaler. tc pulses for one cycle on a wrap step.
//   Optional macro COUNTER_SATURATE_EN: up at MAX_COUNT / down at 0 hold the
//   count instead of wrapping, and tc pulses on each such blocked step.
// Ports:
//   clock       in  rising-edge clock
//   Reset       in  asynchronous active-high reset
//   En          in  count enable; 0 freezes count and prescaler
//   select      in  mode: 00 hold, 01 down, 10 up, 11 load
//   load_value  in  value captured in load mode (clamped to MAX_COUNT)
//   count       out current count (registered)
//   tc          out terminal-count pulse (registered)
//   tick        out prescaler step strobe (registered)
module mode_counter_n
    import mode_counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = (1 << WIDTH) - 1,
    parameter int PRESCALE  = 1
) (
    input  logic             clock,
    input  logic             Reset,
    input  logic             En,
    input  logic [1:0]       select,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             tick
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_COUNT);

    logic step;
    logic load;

    assign load = En && (select == SEL_LOAD);

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clock  (clock),
        .Reset  (Reset),
        .En     (En),
        .clear  (load),
        .tick_en(step),
        .tick   (tick)
    );

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            count <= '0;
            tc    <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                count <= WIDTH'(clamp_load(int'(load_value), MAX_COUNT));
            end else if (step && select == SEL_UP) begin
                if (count == MAX) begin
`ifdef COUNTER_SATURATE_EN
                    count <= count;
`else
                    count <= '0;
`endif
                    tc <= 1'b1;
                end else begin
                    count <= count + WIDTH'(1);
                end
            end else if (step && select == SEL_DOWN) begin
                if (count == '0) begin
`ifdef COUNTER_SATURATE_EN
                    count <= count;
`else
                    count <= MAX;
`endif
                    tc <= 1'b1;
                end else begin
                    count <= count - WIDTH'(1);
                end
            end
        end
    end

endmodule
